// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the master_spi ALU link
package spi_pkg;

  localparam int OPND_W = 4;
  localparam int OP_W   = 2;
  localparam int HDR_W  = 2 * OPND_W + OP_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_XFER_HI = 3'd2,
    ST_XFER_LO = 3'd3,
    ST_HOLD    = 3'd4,
    ST_GAP     = 3'd5
  } spi_state_t;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_t;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - half-period counter marking the first and last cycle of each SPI phase
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_phase_tick,
  output logic o_phase_first
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  // tick on the last cycle of a phase so the FSM changes phase at the following edge
  assign o_phase_tick  = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_phase_first = i_en && (r_cnt == '0);

  // counter restarts at every phase boundary and is held at zero while idle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en || o_phase_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/master_spi.sv
// rtl/master_spi.sv - mode-0 SPI master for the ALU slave link (option: SPI_LOOPBACK_EN)
import spi_pkg::*;

module master_spi #(
  parameter int FRAME_W = 16,
  parameter int CLK_DIV = 2
) (
  input  logic               SLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [OPND_W-1:0]  A,
  input  logic [OPND_W-1:0]  B,
  input  logic [OP_W-1:0]    op,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_data,
  output logic               CS,
  output logic               SLCK,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int BW = $clog2(FRAME_W);

  spi_state_t         r_state;
  logic [FRAME_W-1:0] r_tx;
  logic [FRAME_W-1:0] r_rx;
  logic [FRAME_W-1:0] r_rx_data;
  logic [BW-1:0]      r_bit;
  logic               r_done;

  logic               w_tick;
  logic               w_first;
  logic               w_en;
  logic               w_cs_active;
  logic               w_rx_bit;
  alu_op_t            w_op;
  logic [FRAME_W-1:0] w_frame;

  assign w_op    = alu_op_t'(op);
  assign w_frame = FRAME_W'({A, B, w_op}) << (FRAME_W - HDR_W);
  assign w_en    = (r_state != ST_IDLE);

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk         (SLK),
    .i_rst_n       (RST_N),
    .i_en          (w_en),
    .o_phase_tick  (w_tick),
    .o_phase_first (w_first)
  );

  // pins are decoded from the state so reset takes effect at the very next cycle
  assign w_cs_active = (r_state == ST_SETUP) || (r_state == ST_XFER_HI) ||
                       (r_state == ST_XFER_LO) || (r_state == ST_HOLD);
  assign CS      = !w_cs_active;
  assign SLCK    = (r_state == ST_XFER_HI);
  assign MOSI    = w_cs_active && r_tx[FRAME_W-1];
  assign ready   = (r_state == ST_IDLE);
  assign busy    = (w_en && (r_state != ST_GAP)) || r_done;
  assign done    = r_done;
  assign rx_data = r_rx_data;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_bit = r_tx[FRAME_W-1];
`else
  assign w_rx_bit = MISO;
`endif

  // frame sequencer: shift out on SLCK falling, capture on SLCK rising, publish at GAP entry
  always_ff @(posedge SLK) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_bit     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tx    <= w_frame;
            r_bit   <= BW'(FRAME_W - 1);
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_XFER_HI;
        end
        ST_XFER_HI: begin
          if (w_first) r_rx <= {r_rx[FRAME_W-2:0], w_rx_bit};
          if (w_tick) begin
            r_state <= ST_XFER_LO;
            // the last bit stays on MOSI through HOLD
            if (r_bit != '0) r_tx <= r_tx << 1;
          end
        end
        ST_XFER_LO: begin
          if (w_tick) begin
            if (r_bit == '0) begin
              r_state <= ST_HOLD;
            end else begin
              r_bit   <= r_bit - 1'b1;
              r_state <= ST_XFER_HI;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_state   <= ST_GAP;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end
        end
        ST_GAP: begin
          if (w_tick) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_master_spi.sv
// tb/tb_master_spi.sv - scoreboard bench for master_spi
module tb_master_spi;

  localparam int FRAME_W   = 16;
  localparam int CLK_DIV   = 2;
  localparam int FRAME_CYC = CLK_DIV * (2 * FRAME_W + 2);

  logic        SLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  A = '0;
  logic [3:0]  B = '0;
  logic [1:0]  op = '0;
  logic        MISO;
  logic        ready, busy, done, CS, SLCK, MOSI;
  logic [15:0] rx_data;

  always #5 SLK = ~SLK;

  master_spi #(.FRAME_W(FRAME_W), .CLK_DIV(CLK_DIV)) dut (
    .SLK(SLK), .RST_N(RST_N), .start(start), .A(A), .B(B), .op(op),
    .ready(ready), .busy(busy), .done(done), .rx_data(rx_data),
    .CS(CS), .SLCK(SLCK), .MOSI(MOSI), .MISO(MISO)
  );

  typedef struct {
    logic [15:0] tx;
    logic [15:0] rx;
    int          done_cyc;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_exp = 0;
  logic [15:0] resp = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge SLK) cyc++;

  // slave: presents MSB while CS high, advances on each SLCK falling edge
  logic [15:0] s_sr = '0;
  logic        s_prev_slck = 1'b0;
  always @(posedge SLK) begin
    #1;
    if (CS) s_sr = resp;
    else if (s_prev_slck && !SLCK) s_sr = s_sr << 1;
    s_prev_slck = SLCK;
  end
  assign MISO = s_sr[15];

  // monitor: captures pin activity and checks each done against the scoreboard
  logic [15:0] cap = '0;
  int          edges = 0, cs_low = 0, hi_run = 0, last_gap = -1;
  logic        m_prev_slck = 1'b0, m_prev_cs = 1'b1;
  always @(negedge SLK) begin
    if (!RST_N) begin
      cap = '0; edges = 0; cs_low = 0; hi_run = 0; last_gap = -1;
      m_prev_slck = 1'b0; m_prev_cs = 1'b1;
    end else begin
      if (!CS) begin
        if (m_prev_cs) last_gap = hi_run;
        cs_low++;
        if (SLCK && !m_prev_slck) begin
          cap = {cap[14:0], MOSI};
          edges++;
        end
      end else begin
        hi_run = m_prev_cs ? hi_run + 1 : 1;
      end
      m_prev_slck = SLCK;
      m_prev_cs   = CS;
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 cycle=%0d", cyc);
        end else begin
          m_e = sb.pop_front();
          chk("rx_data", 32'(rx_data), 32'(m_e.rx));
          chk("mosi_frame", 32'(cap), 32'(m_e.tx));
          chk("slck_rises", edges, FRAME_W);
          chk("cs_low_cycles", cs_low, FRAME_CYC);
          chk("done_cycle", cyc, m_e.done_cyc);
          chk("busy_at_done", 32'(busy), 1);
          if (m_e.gap >= 0) chk("cs_gap", last_gap, m_e.gap);
        end
        cap = '0; edges = 0; cs_low = 0;
      end
    end
  end

  function automatic logic [15:0] exp_rx(input logic [15:0] tx, input logic [15:0] r);
`ifdef SPI_LOOPBACK_EN
    return tx;
`else
    return r;
`endif
  endfunction

  task automatic push(input logic [15:0] tx, input logic [15:0] r, input int dcyc, input int gap);
    exp_t t;
    t.tx = tx; t.rx = exp_rx(tx, r); t.done_cyc = dcyc; t.gap = gap;
    sb.push_back(t);
    n_exp++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cs"}, 32'(CS), 1);
    chk({tag, "_slck"}, 32'(SLCK), 0);
    chk({tag, "_mosi"}, 32'(MOSI), 0);
    chk({tag, "_ready"}, 32'(ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
  endtask

  // one start pulse, operands scrambled after accept, then wait out the frame
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] o,
                      input logic [15:0] tx, input logic [15:0] r);
    resp = r; A = a; B = b; op = o;
    @(negedge SLK);
    start = 1'b1;
    push(tx, r, cyc + FRAME_CYC + 1, -1);
    @(negedge SLK);
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom); op = 2'($urandom);
    chk("busy_after_accept", 32'(busy), 1);
    chk("ready_after_accept", 32'(ready), 0);
    repeat (FRAME_CYC + 6) @(negedge SLK);
  endtask

  int c0;

  initial begin
    RST_N = 1'b0;
    repeat (3) @(negedge SLK);
    RST_N = 1'b1;
    @(negedge SLK);
    check_idle("reset");

    // basic frame
    send(4'h1, 4'h3, 2'd0, 16'h1300, 16'hA5C3);

    // start during a transfer is ignored
    resp = 16'h5A3C; A = 4'h1; B = 4'h3; op = 2'd0;
    @(negedge SLK);
    start = 1'b1;
    push(16'h1300, 16'h5A3C, cyc + FRAME_CYC + 1, -1);
    @(negedge SLK);
    start = 1'b0;
    repeat (30) @(negedge SLK);
    A = 4'hF; start = 1'b1;
    repeat (4) @(negedge SLK);
    start = 1'b0;
    repeat (FRAME_CYC) @(negedge SLK);

    // back-to-back with start held high: period = frame + minimum gap
    resp = 16'h0F0F; A = 4'h2; B = 4'h5; op = 2'd3;
    @(negedge SLK);
    start = 1'b1;
    c0 = cyc;
    push(16'h25C0, 16'h0F0F, c0 + FRAME_CYC + 1, -1);
    push(16'h25C0, 16'h0F0F, c0 + 2 * (FRAME_CYC + CLK_DIV + 1) + FRAME_CYC + 1 - (FRAME_CYC + CLK_DIV + 1), CLK_DIV + 1);
    push(16'h25C0, 16'h0F0F, c0 + 2 * (FRAME_CYC + CLK_DIV + 1) + FRAME_CYC + 1, CLK_DIV + 1);
    repeat (150) @(negedge SLK);
    start = 1'b0;
    while (cyc < c0 + 220) @(negedge SLK);

    // reset in the high phase of bit 7 aborts the frame
    resp = 16'h1234; A = 4'h4; B = 4'h6; op = 2'd1;
    @(negedge SLK);
    start = 1'b1;
    @(negedge SLK);
    start = 1'b0;
    repeat (34) @(negedge SLK);
    chk("mid_slck_high", 32'(SLCK), 1);
    RST_N = 1'b0;
    @(negedge SLK);
    check_idle("mid_reset");
    RST_N = 1'b1;
    repeat (FRAME_CYC + 10) @(negedge SLK);

    // fresh frame after abort
    send(4'h7, 4'h1, 2'd2, 16'h7180, 16'hC3A5);

    // loopback vector; MISO held low when looping back
`ifdef SPI_LOOPBACK_EN
    send(4'hA, 4'h5, 2'd2, 16'hA580, 16'h0000);
`else
    send(4'hA, 4'h5, 2'd2, 16'hA580, 16'h3C5A);
`endif

    repeat (10) @(negedge SLK);
    chk("pending_expected", sb.size(), 0);
    chk("done_count", n_done, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
